// File: rtl/fpm_pkg.sv
// Shared definitions for the FP multiplier issue/retire controller.
package fpm_pkg;

    localparam int LAT_FPM   = 7;
    localparam int DEPTH_FPM = 8;
    localparam int TAG_W_FPM = 4;
    localparam int RES_W     = 32;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fpm_res_t;

    typedef logic [TAG_W_FPM-1:0] fpm_tag_t;

    // Assembles a packed result word from its IEEE-754 single-precision fields.
    function automatic fpm_res_t fpm_pack(input logic sign, input logic [7:0] exp,
                                          input logic [22:0] mant);
        fpm_res_t r;
        r.sign = sign;
        r.exp  = exp;
        r.mant = mant;
        return r;
    endfunction

endpackage

// File: rtl/fpm_res_fifo.sv
// Result FIFO for the FP multiplier pipeline: DEPTH entries, wrap-at-DEPTH
// pointers (any DEPTH >= 1), separate occupancy count, combinational head.
module fpm_res_fifo
    import fpm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             doPush;
    logic             doPop;

    // Pointers wrap explicitly so non-power-of-two depths never index past the end.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers and count; a push into a full FIFO only lands when a pop frees the head.
    always_comb begin
        full    = (count_q == FULL_CNT);
        doPop   = pop_i && (count_q != '0);
        doPush  = push_i && (!full || doPop);
        wrPtr_d = doPush ? ptrInc(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop  ? ptrInc(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    noOverflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/fpm_issue_ctrl.sv
// Issue/retire controller for the 7-stage FP multiplier: credit-based
// admission, validity/tag tracking alongside the datapath, result FIFO.
module fpm_issue_ctrl
    import fpm_pkg::*;
#(
    parameter int LAT   = fpm_pkg::LAT_FPM,
    parameter int DEPTH = fpm_pkg::DEPTH_FPM,
    parameter int TAG_W = fpm_pkg::TAG_W_FPM,
    parameter int RES_W = fpm_pkg::RES_W,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             in_ready_o,
    output logic             issue_o,
    input  logic [RES_W-1:0] pipe_res_i,
    output logic             out_valid_o,
    output logic [RES_W-1:0] out_res_o,
    output logic [TAG_W-1:0] out_tag_o,
    input  logic             out_ready_i,
    output logic [OCC_W-1:0] occ_o,
    output logic             busy_o
);

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [LAT:1]           vld_q;
    logic [TAG_W-1:0]       tg_q [1:LAT];
    logic                   popHead;
    logic [OCC_W-1:0]       fifoCount;
    logic [RES_W+TAG_W-1:0] fifoHead;

    // Every accepted op holds a credit until popped, so occ bounds FIFO fill.
    assign in_ready_o = !rst_i && (occ_q < OCC_MAX);
    assign issue_o    = in_valid_i && in_ready_o;
    assign popHead    = out_valid_o && out_ready_i;

    // Credit counter: issue takes one, pop returns one, both together cancel.
    always_comb begin
        occ_d = occ_q;
        if (issue_o && !popHead) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (popHead && !issue_o) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Credit register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Valid/tag shadow of the free-running datapath stages; reset discards in-flight ops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 1; k <= LAT; k++) begin
                tg_q[k] <= '0;
            end
        end else begin
            vld_q[1] <= issue_o;
            tg_q[1]  <= in_tag_i;
            for (int k = 2; k <= LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tg_q[k]  <= tg_q[k-1];
            end
        end
    end

    fpm_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W + TAG_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (vld_q[LAT]),
        .data_i  ({pipe_res_i, tg_q[LAT]}),
        .pop_i   (popHead),
        .valid_o (out_valid_o),
        .data_o  (fifoHead),
        .count_o (fifoCount)
    );

    assign out_res_o = fifoHead[RES_W+TAG_W-1:TAG_W];
    assign out_tag_o = fifoHead[TAG_W-1:0];
    assign occ_o     = occ_q;
    assign busy_o    = (occ_q != '0);

    fifoWithinCredit: assert property (@(posedge clk_i) disable iff (rst_i)
        fifoCount <= occ_q);

endmodule

// File: tb/tb_fpm_issue_ctrl.sv
// Self-checking bench for fpm_issue_ctrl: reset table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fpm_issue_ctrl;

    localparam int LAT   = 7;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, inValid, inReady, issue, outValid, outReady, busy;
    logic [3:0]  inTag, outTag, occ;
    logic [31:0] pipeRes, outRes;

    fpm_issue_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_tag_i    (inTag),
        .in_ready_o  (inReady),
        .issue_o     (issue),
        .pipe_res_i  (pipeRes),
        .out_valid_o (outValid),
        .out_res_o   (outRes),
        .out_tag_o   (outTag),
        .out_ready_i (outReady),
        .occ_o       (occ),
        .busy_o      (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference model: ops in flight with their retire cycle, and stored results.
    typedef struct { logic [3:0] tag; int due; } flight_t;
    typedef struct { logic [31:0] res; logic [3:0] tag; } result_t;
    flight_t flightQ[$];
    result_t resQ[$];

    typedef struct {
        logic r; logic v; logic [3:0] tag; logic ordy;
        logic eReady; logic eIssue; logic eOutValid; logic [3:0] eOcc;
    } vec_t;
    vec_t tbl[9];

    int   cyc = 0;
    int   vecs = 0;
    int   miscompares = 0;
    int   modelIssues = 0;
    logic eReady, eIssue, eOutValid;
    logic sReady, sIssue, sOutValid;
    logic [3:0]  sOcc, sTag;
    logic [31:0] sRes;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT outputs with the model in the middle of the cycle.
    task automatic checkOutput();
        int modelOcc;
        modelOcc  = flightQ.size() + resQ.size();
        eReady    = !rst && (modelOcc < DEPTH);
        eIssue    = inValid && eReady;
        eOutValid = (resQ.size() != 0);
        sReady = inReady; sIssue = issue; sOutValid = outValid;
        sOcc = occ; sTag = outTag; sRes = outRes;
        cmp("in_ready", 32'(inReady), 32'(eReady));
        cmp("issue", 32'(issue), 32'(eIssue));
        cmp("out_valid", 32'(outValid), 32'(eOutValid));
        cmp("occ", 32'(occ), 32'(modelOcc));
        cmp("busy", 32'(busy), 32'(modelOcc != 0));
        if (eOutValid) begin
            cmp("out_tag", 32'(outTag), 32'(resQ[0].tag));
            cmp("out_res", outRes, resQ[0].res);
        end
    endtask

    // Advance the model across the clock edge that just happened.
    task automatic updateModel();
        if (rst) begin
            flightQ.delete();
            resQ.delete();
        end else begin
            if (eOutValid && outReady) void'(resQ.pop_front());
            if (flightQ.size() != 0 && flightQ[0].due == cyc) begin
                resQ.push_back('{res: pipeRes, tag: flightQ[0].tag});
                void'(flightQ.pop_front());
            end
            if (eIssue) begin
                flightQ.push_back('{tag: inTag, due: cyc + LAT});
                modelIssues++;
            end
        end
        cyc++;
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step past the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] tag,
                                 input logic ordy, input logic [31:0] pres);
        rst = r; inValid = v; inTag = tag; outReady = ordy; pipeRes = pres;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    // Abort guard in case the run ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        int issues;
        int pops;
        int maxOcc;

        rst = 1'b1; inValid = 1'b1; inTag = 4'h0; outReady = 1'b0; pipeRes = 32'h0;
        @(posedge clk);
        #1;

        tbl[0] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[5] = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].r, tbl[i].v, tbl[i].tag, tbl[i].ordy, $urandom);
            cmp("tbl_in_ready", 32'(sReady), 32'(tbl[i].eReady));
            cmp("tbl_issue", 32'(sIssue), 32'(tbl[i].eIssue));
            cmp("tbl_out_valid", 32'(sOutValid), 32'(tbl[i].eOutValid));
            cmp("tbl_occ", 32'(sOcc), 32'(tbl[i].eOcc));
        end

        $display("[TB] single op latency");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, $urandom);
        cmp("single_issue", 32'(sIssue), 32'd1);
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, (k == LAT) ? 32'h3F800000 : $urandom);
        end
        cmp("single_not_early", 32'(sOutValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
        cmp("single_out_valid", 32'(sOutValid), 32'd1);
        cmp("single_out_tag", 32'(sTag), 32'h3);
        cmp("single_out_res", sRes, 32'h3F800000);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);

        $display("[TB] streaming");
        modelIssues = 0; pops = 0; maxOcc = 0;
        for (int i = 0; i < 50 + 14; i++) begin
            applyStimulus(1'b0, i < 50, 4'(i % 16), 1'b1, $urandom);
            if (sOutValid === 1'b1) pops++;
            if (int'(sOcc) > maxOcc) maxOcc = int'(sOcc);
        end
        cmp("stream_pops", 32'(pops), 32'(modelIssues));
        cmp("stream_occ_bound", 32'(maxOcc <= DEPTH), 32'd1);
        cmp("stream_idle", 32'(sOcc), 32'd0);

        $display("[TB] backpressure");
        issues = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 4'($urandom), 1'b0, $urandom);
            if (sIssue === 1'b1) issues++;
        end
        cmp("bp_issue_count", 32'(issues), 32'd8);
        cmp("bp_in_ready_low", 32'(sReady), 32'd0);
        cmp("bp_all_stored", 32'(sOutValid), 32'd1);
        cmp("bp_occ_full", 32'(sOcc), 32'd8);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, $urandom);
        cmp("full_no_issue", 32'(sIssue), 32'd0);
        cmp("full_pop", 32'(sOutValid), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h6, 1'b1, $urandom);
        cmp("ready_after_pop", 32'(sReady), 32'd1);
        cmp("issue_and_pop", 32'(sIssue), 32'd1);
        cmp("occ_7_before", 32'(sOcc), 32'd7);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
        cmp("occ_7_after", 32'(sOcc), 32'd7);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
        cmp("bp_drained", 32'(sOcc), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, $urandom);
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b0, $urandom);
        for (int i = 0; i < LAT; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, $urandom);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'(i), 1'b0, $urandom);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, $urandom);
        cmp("rst_pre_occ", 32'(sOcc), 32'd7);
        cmp("rst_pre_valid", 32'(sOutValid), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
        cmp("rst_post_valid", 32'(sOutValid), 32'd0);
        cmp("rst_post_occ", 32'(sOcc), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, $urandom);
            cmp("rst_no_stale", 32'(sOutValid), 32'd0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                          4'($urandom), (i % 100 < 50) ? ($urandom_range(0, 3) == 0)
                                                       : ($urandom_range(0, 3) != 0),
                          $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
